// File: rtl/opl3_pkg.sv
// Shared OPL3 definitions: ISA port map, wired-order bit swap and bridge FSM states.
package opl3_pkg;

  localparam logic [9:0] OPL_BASE = 10'h388;

  localparam logic [1:0] OFS_IDX0 = 2'd0;
  localparam logic [1:0] OFS_DAT0 = 2'd1;
  localparam logic [1:0] OFS_IDX1 = 2'd2;
  localparam logic [1:0] OFS_DAT1 = 2'd3;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_QUAL,
    WR_CAPTURE,
    WR_WAIT_HI
  } isa_wr_state_t;

  // The board swaps data bits pairwise; the swap is its own inverse.
  function automatic logic [7:0] isa_unswap(input logic [7:0] w);
    return {w[6], w[7], w[4], w[5], w[2], w[3], w[0], w[1]};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a group of asynchronous bus inputs.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/isa_opl_bridge.sv
// ISA front end for the OPL3 core: synchronizes the bus, qualifies IOW strobes,
// decodes the four OPL3 ports into register writes and returns status on reads.
module isa_opl_bridge
  import opl3_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = OPL_BASE,
  parameter int         FILTER    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] isa_addr,
  input  logic       isa_aen,
  input  logic       isa_iow_n,
  input  logic       isa_ior_n,
  input  logic [7:0] isa_data_in,
  output logic [7:0] isa_data_out,
  output logic       isa_data_oe,
  input  logic [7:0] status,
  output logic       reg_we,
  output logic [8:0] reg_addr,
  output logic [7:0] reg_data
);

  localparam logic [3:0] FILT = 4'(FILTER);

  logic        iow_n_p2, ior_n_p2, aen_p2;
  logic [9:0]  addr_p2;
  logic [7:0]  data_p2;

  sync2 #(.W(2), .RST_VAL(2'b11)) u_sync_strobe (
    .clk(clk), .rst_n(rst_n),
    .d({isa_iow_n, isa_ior_n}), .q({iow_n_p2, ior_n_p2})
  );

  sync2 #(.W(11), .RST_VAL(11'd0)) u_sync_addr (
    .clk(clk), .rst_n(rst_n),
    .d({isa_aen, isa_addr}), .q({aen_p2, addr_p2})
  );

  sync2 #(.W(8), .RST_VAL(8'd0)) u_sync_data (
    .clk(clk), .rst_n(rst_n),
    .d(isa_data_in), .q(data_p2)
  );

  isa_wr_state_t state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [3:0]    cnt_inc;

  assign cnt_inc = {1'b0, cnt} + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WR_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE cycle that first sees iow_n low counts as the first qualifying sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WR_IDLE: begin
        if (!iow_n_p2) begin
          state_nxt = WR_QUAL;
          cnt_nxt   = 3'd1;
        end
      end
      WR_QUAL: begin
        if (iow_n_p2)           state_nxt = WR_IDLE;
        else if (cnt_inc >= FILT) state_nxt = WR_CAPTURE;
        else                    cnt_nxt   = cnt_inc[2:0];
      end
      WR_CAPTURE: state_nxt = WR_WAIT_HI;
      WR_WAIT_HI: if (iow_n_p2) state_nxt = WR_IDLE;
      default:    state_nxt = WR_IDLE;
    endcase
  end

  logic [9:0] ofs_full;
  logic       win_hit;
  logic [7:0] index;
  logic       bank;
  logic [7:0] data_log;

  assign ofs_full = addr_p2 - BASE_ADDR;
  assign win_hit  = (ofs_full[9:2] == 8'd0) && !aen_p2;
  assign data_log = isa_unswap(data_p2);

  // Capture and decode: the data ports reuse the bank of the latest index write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we   <= 1'b0;
      reg_addr <= 9'd0;
      reg_data <= 8'd0;
      index    <= 8'd0;
      bank     <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (state == WR_CAPTURE && win_hit) begin
        case (ofs_full[1:0])
          OFS_IDX0: begin
            index <= data_log;
            bank  <= 1'b0;
          end
          OFS_IDX1: begin
            index <= data_log;
            bank  <= 1'b1;
          end
          OFS_DAT0, OFS_DAT1: begin
            reg_we   <= 1'b1;
            reg_addr <= {bank, index};
            reg_data <= data_log;
          end
          default: ;
        endcase
      end
    end
  end

  logic rd_hit;

  assign rd_hit = !ior_n_p2 && !aen_p2 && (state == WR_IDLE) &&
                  ((addr_p2 == BASE_ADDR) || (addr_p2 == BASE_ADDR + 10'd2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isa_data_oe  <= 1'b0;
      isa_data_out <= 8'd0;
    end else begin
      isa_data_oe  <= rd_hit;
      isa_data_out <= rd_hit ? isa_unswap(status) : 8'd0;
    end
  end

endmodule

// File: tb/tb_isa_opl_bridge.sv
// Directed bench for isa_opl_bridge: writes, banking, rejection, reads and reset.
module tb_isa_opl_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] isa_addr;
  logic       isa_aen;
  logic       isa_iow_n;
  logic       isa_ior_n;
  logic [7:0] isa_data_in;
  logic [7:0] isa_data_out;
  logic       isa_data_oe;
  logic [7:0] status;
  logic       reg_we;
  logic [8:0] reg_addr;
  logic [7:0] reg_data;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  isa_opl_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .isa_addr(isa_addr), .isa_aen(isa_aen),
    .isa_iow_n(isa_iow_n), .isa_ior_n(isa_ior_n),
    .isa_data_in(isa_data_in), .isa_data_out(isa_data_out),
    .isa_data_oe(isa_data_oe), .status(status),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data)
  );

  always @(negedge clk) if (reg_we === 1'b1) we_cnt++;

  task automatic isa_write(input logic [9:0] a, input logic [7:0] wd,
                           input logic aen, input int width);
    @(posedge clk); #1;
    isa_addr = a; isa_data_in = wd; isa_aen = aen; isa_iow_n = 1'b0;
    repeat (width) @(posedge clk);
    #1 isa_iow_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 isa_aen = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; isa_addr = '0; isa_aen = 1'b0; isa_iow_n = 1'b1;
    isa_ior_n = 1'b1; isa_data_in = '0; status = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({reg_we, reg_addr, reg_data, isa_data_oe, isa_data_out} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h oe=%b dout=%h, want all 0",
               reg_we, reg_addr, reg_data, isa_data_oe, isa_data_out);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_bank0;
    int base;
    isa_write(10'h388, 8'h40, 1'b0, 6);
    base = we_cnt;
    @(posedge clk); #1;
    isa_addr = 10'h389; isa_data_in = 8'h00; isa_iow_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (reg_we !== 1'b0) begin
      errors++; $display("FAIL bank0_early_we: got %b want 0", reg_we);
    end
    @(posedge clk); #1;
    checks++;
    if (reg_we !== 1'b1) begin
      errors++; $display("FAIL bank0_latency: reg_we got %b want 1 at cycle 5", reg_we);
    end
    checks++;
    if (reg_addr !== 9'h080 || reg_data !== 8'h00) begin
      errors++; $display("FAIL bank0_addr_data: got %h/%h want 080/00", reg_addr, reg_data);
    end
    @(posedge clk); #1 isa_iow_n = 1'b1;
    repeat (8) @(posedge clk);
    checks++;
    if (we_cnt - base !== 1) begin
      errors++; $display("FAIL bank0_pulse_count: got %0d want 1", we_cnt - base);
    end
  endtask

  task automatic test_bank1;
    isa_write(10'h388, 8'h0A, 1'b0, 6);
    isa_write(10'h38B, 8'h02, 1'b0, 6);
    checks++;
    if (reg_addr !== 9'h005 || reg_data !== 8'h01) begin
      errors++; $display("FAIL bank1_odd_port_bank0: got %h/%h want 005/01", reg_addr, reg_data);
    end
    isa_write(10'h38A, 8'h70, 1'b0, 6);
    isa_write(10'h38B, 8'h32, 1'b0, 6);
    checks++;
    if (reg_addr !== 9'h1B0 || reg_data !== 8'h31) begin
      errors++; $display("FAIL bank1_write: got %h/%h want 1b0/31", reg_addr, reg_data);
    end
  endtask

  task automatic test_reject;
    int base;
    base = we_cnt;
    isa_write(10'h389, 8'hFF, 1'b0, 1);
    checks++;
    if (we_cnt !== base) begin
      errors++; $display("FAIL glitch_reject: got %0d pulses want 0", we_cnt - base);
    end
    isa_write(10'h389, 8'hFF, 1'b1, 8);
    checks++;
    if (we_cnt !== base) begin
      errors++; $display("FAIL aen_reject: got %0d pulses want 0", we_cnt - base);
    end
    isa_write(10'h300, 8'hFF, 1'b0, 8);
    checks++;
    if (we_cnt !== base) begin
      errors++; $display("FAIL addr_reject: got %0d pulses want 0", we_cnt - base);
    end
  endtask

  task automatic test_long_strobe;
    int base;
    base = we_cnt;
    isa_write(10'h389, 8'h55, 1'b0, 40);
    checks++;
    if (we_cnt - base !== 1) begin
      errors++; $display("FAIL long_strobe_pulses: got %0d want 1", we_cnt - base);
    end
  endtask

  task automatic test_status_read;
    status = 8'hE0;
    @(posedge clk); #1;
    isa_addr = 10'h388; isa_ior_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (isa_data_oe !== 1'b0) begin
      errors++; $display("FAIL read_oe_early: got %b want 0", isa_data_oe);
    end
    @(posedge clk); #1;
    checks++;
    if (isa_data_oe !== 1'b1 || isa_data_out !== 8'hD0) begin
      errors++; $display("FAIL read_status: got oe=%b dout=%h want 1/d0", isa_data_oe, isa_data_out);
    end
    isa_ior_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (isa_data_oe !== 1'b1) begin
      errors++; $display("FAIL read_oe_hold: got %b want 1", isa_data_oe);
    end
    @(posedge clk); #1;
    checks++;
    if (isa_data_oe !== 1'b0) begin
      errors++; $display("FAIL read_oe_release: got %b want 0", isa_data_oe);
    end
    isa_addr = 10'h389; isa_ior_n = 1'b0;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (isa_data_oe !== 1'b0) begin
      errors++; $display("FAIL read_wrong_port: got oe=%b want 0", isa_data_oe);
    end
    isa_ior_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid_write;
    int base;
    base = we_cnt;
    @(posedge clk); #1;
    isa_addr = 10'h389; isa_data_in = 8'h10; isa_iow_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_we, reg_addr, reg_data, isa_data_oe, isa_data_out} !== 27'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%b addr=%h data=%h oe=%b dout=%h, want all 0",
               reg_we, reg_addr, reg_data, isa_data_oe, isa_data_out);
    end
    isa_iow_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    checks++;
    if (we_cnt !== base) begin
      errors++; $display("FAIL midreset_no_we: got %0d pulses want 0", we_cnt - base);
    end
    isa_write(10'h388, 8'h40, 1'b0, 6);
    isa_write(10'h389, 8'h02, 1'b0, 6);
    checks++;
    if (we_cnt - base !== 1 || reg_addr !== 9'h080 || reg_data !== 8'h01) begin
      errors++;
      $display("FAIL midreset_fresh_write: got n=%0d %h/%h want 1 080/01",
               we_cnt - base, reg_addr, reg_data);
    end
  endtask

  initial begin
    test_reset;
    test_bank0;
    test_bank1;
    test_reject;
    test_long_strobe;
    test_status_read;
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
